// File: rtl/vga_pkg.sv
// Shared timing defaults, colour types and test-pattern colour codes for the VGA timing generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CW       = 8;

    typedef struct packed {
        logic [DEF_CW-1:0] r;
        logic [DEF_CW-1:0] g;
        logic [DEF_CW-1:0] b;
    } rgb_t;

    // Test-pattern colours as {R,G,B} enables; each set bit expands to an all-ones channel.
    localparam logic [2:0] TP_WHITE   = 3'b111;
    localparam logic [2:0] TP_YELLOW  = 3'b110;
    localparam logic [2:0] TP_CYAN    = 3'b011;
    localparam logic [2:0] TP_GREEN   = 3'b010;
    localparam logic [2:0] TP_MAGENTA = 3'b101;
    localparam logic [2:0] TP_RED     = 3'b100;
    localparam logic [2:0] TP_BLUE    = 3'b001;
    localparam logic [2:0] TP_BLACK   = 3'b000;

    localparam logic [2:0] TP_BARS [0:7] = '{
        TP_WHITE, TP_YELLOW, TP_CYAN, TP_GREEN,
        TP_MAGENTA, TP_RED, TP_BLUE, TP_BLACK
    };

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-area and sync-window decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W     = clog2_min1(TOTAL)
) (
    input  logic         clk,
    input  logic         RST_BTN,
    input  logic         ce,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    if (ACTIVE < 1 || SYNC < 1) begin : g_bad_params
        $error("vga_axis_counter: ACTIVE and SYNC must both be non-zero");
    end

    logic [W-1:0] cnt_reg;
    logic         in_sync;

    always_ff @(posedge clk) begin
        if (!RST_BTN) begin
            cnt_reg <= '0;
        end else if (ce) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Compared as int so a sync window ending exactly at 2**W cannot alias to zero.
    assign in_sync = (int'(cnt_reg) >= ACTIVE + FP) && (int'(cnt_reg) < ACTIVE + FP + SYNC);

    assign cnt    = cnt_reg;
    assign active = (int'(cnt_reg) < ACTIVE);
    assign sync   = in_sync ? POL : !POL;
    assign wrap   = (cnt_reg == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered pixel output stage and line/frame strobes.
// Optional internal colour-bar source enabled by defining VGA_TEST_PATTERN_EN (adds port tp_on).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CW       = DEF_CW,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = clog2_min1(H_TOTAL),
    localparam int VW      = clog2_min1(V_TOTAL)
) (
    input  logic          clk,
    input  logic          RST_BTN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          tp_on,
`endif
    input  logic [3*CW-1:0] rgb_in,
    output logic          pix_req,
    output logic [HW-1:0] pix_x,
    output logic [VW-1:0] pix_y,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          de,
    output logic [CW-1:0] VGA_R,
    output logic [CW-1:0] VGA_G,
    output logic [CW-1:0] VGA_B,
    output logic          line_start,
    output logic          frame_start
);

    localparam int DW = clog2_min1(CLK_DIV);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end

    logic pix_ce;

    if (CLK_DIV > 1) begin : g_div
        localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
        logic [DW-1:0] div_reg;

        always_ff @(posedge clk) begin
            if (!RST_BTN) begin
                div_reg <= '0;
            end else if (div_reg == DIV_LAST) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end

        assign pix_ce = (div_reg == DIV_LAST);
    end else begin : g_no_div
        assign pix_ce = 1'b1;
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_active;
    logic          v_active;
    logic          h_sync;
    logic          v_sync;
    logic          h_wrap;
    logic          v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk     (clk),
        .RST_BTN (RST_BTN),
        .ce      (pix_ce),
        .cnt     (h_cnt),
        .active  (h_active),
        .sync    (h_sync),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk     (clk),
        .RST_BTN (RST_BTN),
        .ce      (pix_ce & h_wrap),
        .cnt     (v_cnt),
        .active  (v_active),
        .sync    (v_sync),
        .wrap    (v_wrap_unused)
    );

    assign pix_x   = h_cnt;
    assign pix_y   = v_cnt;
    assign pix_req = h_active & v_active;

    logic [3*CW-1:0] colour;

`ifdef VGA_TEST_PATTERN_EN
    // Bars are found by threshold compare rather than division; bar 7 takes any remainder.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
    logic [2:0] bar_sel;
    logic [2:0] bar_code;

    always_comb begin
        bar_sel = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (int'(h_cnt) < (i + 1) * BAR_W) begin
                bar_sel = 3'(i);
            end
        end
        bar_code = TP_BARS[bar_sel];
        if (tp_on) begin
            colour = {{CW{bar_code[2]}}, {CW{bar_code[1]}}, {CW{bar_code[0]}}};
        end else begin
            colour = rgb_in;
        end
    end
`else
    assign colour = rgb_in;
`endif

    logic [3*CW-1:0] rgb_out;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [CW-1:0] chan_reg;

        always_ff @(posedge clk) begin
            if (!RST_BTN) begin
                chan_reg <= '0;
            end else if (pix_ce) begin
                chan_reg <= pix_req ? colour[(2-gi)*CW +: CW] : '0;
            end
        end

        assign rgb_out[(2-gi)*CW +: CW] = chan_reg;
    end

    logic hsync_reg;
    logic vsync_reg;
    logic de_reg;
    logic line_start_reg;
    logic frame_start_reg;

    // Strobes are cleared every clk so they last one clk even when pix_ce is divided down.
    always_ff @(posedge clk) begin
        if (!RST_BTN) begin
            hsync_reg       <= !HS_POL;
            vsync_reg       <= !VS_POL;
            de_reg          <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            if (pix_ce) begin
                hsync_reg       <= h_sync;
                vsync_reg       <= v_sync;
                de_reg          <= pix_req;
                line_start_reg  <= (h_cnt == '0) && v_active;
                frame_start_reg <= (h_cnt == '0) && (v_cnt == '0);
            end
        end
    end

    assign HSYNC       = hsync_reg;
    assign VSYNC       = vsync_reg;
    assign de          = de_reg;
    assign VGA_R       = rgb_out[3*CW-1 -: CW];
    assign VGA_G       = rgb_out[2*CW-1 -: CW];
    assign VGA_B       = rgb_out[CW-1 -: CW];
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule
